soc_bus_fabric: RTL and testbench
=================================

SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width (>=5).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for a slave ack (1..65535).
REQ-005 SHALL have clk  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have m_req  input  2  per-master request; bit 0 is the core data port, bit 1 is the loader/debug port.
REQ-008 SHALL have m_we  input  2*(DATA_WIDTH/8)  per-master byte write strobes; all zero means read.
REQ-009 SHALL have m_addr  input  2*ADDR_WIDTH  per-master address.
REQ-010 SHALL have m_wdata  input  2*DATA_WIDTH  per-master write data.
REQ-011 SHALL have m_ack  output  2  per-master one-cycle completion pulse.
REQ-012 SHALL have m_err  output  2  per-master error flag, valid with m_ack.
REQ-013 SHALL have m_rdata  output  DATA_WIDTH  read data, shared by both masters, valid with m_ack.
REQ-014 SHALL have s_req  output  NUM_SLV  per-slave request.
REQ-015 SHALL have s_we, s_addr, s_wdata  output  DATA_WIDTH/8, ADDR_WIDTH, DATA_WIDTH  shared to all slaves.
REQ-016 SHALL have s_ack  input  NUM_SLV  per-slave completion.
REQ-017 SHALL have s_rdata  input  NUM_SLV*DATA_WIDTH  per-slave read data.

Function
REQ-018 SHALL decode the slave index from addr[ADDR_WIDTH-1:ADDR_WIDTH-4]; an index >= NUM_SLV is unmapped.
REQ-019 SHALL implement states IDLE, BUSY, RESP.
REQ-020 IDLE: when any m_req bit is set, SHALL grant one master, latch its we/addr/wdata, and go to BUSY, or go to RESP with error if the address is unmapped.
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests, grant the master not granted last; the pointer updates in RESP; after reset, master 0 wins first.
REQ-022 BUSY: s_req[sel] SHALL be 1 and all other s_req bits 0; s_we, s_addr, s_wdata SHALL hold the latched values.
REQ-023 BUSY: s_ack[sel]=1 SHALL capture s_rdata[sel] (zero on writes) and go to RESP; s_ack from non-selected slaves SHALL be ignored.
REQ-024 BUSY: a wait counter SHALL increment each cycle; when it reaches TIMEOUT without ack, SHALL go to RESP with err=1 and rdata=0, and drop s_req.
REQ-025 RESP: SHALL assert m_ack and m_err (if error) for the granted master for exactly one cycle, then return to IDLE.
REQ-026 Latency: request seen in cycle N, s_req in cycle N+1, ack in cycle N+1 gives m_ack in cycle N+2; an unmapped address gives m_ack in cycle N+1.
REQ-027 Masters SHALL hold req and payload stable until m_ack; changes after grant SHALL NOT affect the latched transaction.
REQ-028 A master deasserting req before grant SHALL be treated as no request.
REQ-029 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, clear on entering BUSY, and never wrap.
REQ-030 m_rdata SHALL hold its last value outside RESP.

Reset
REQ-031 When rst=1 at a clock edge: state=IDLE, rr pointer=master 1 (so master 0 wins first), counter=0, m_ack=0, m_err=0, m_rdata=0, s_req=0, s_we=0, s_addr=0, s_wdata=0.
REQ-032 A reset asserted mid-transaction SHALL abandon the transaction with no m_ack, and s_req SHALL be 0 in the following cycle.

Verification
REQ-033 Master 0 reads 0x1000_0004, slave 1 acks in the same cycle with 0xDEADBEEF -> m_ack[0] two cycles after req, m_rdata=0xDEADBEEF, m_err=0.
REQ-034 Both masters request in the same cycle after reset (slave 0 and slave 2) -> master 0 served first, then master 1; repeating the test serves master 1 first.
REQ-035 Master 1 writes m_we=4'b0011 to 0x2000_0000 with data 0x12345678 -> s_we=4'b0011, s_addr=0x2000_0000, s_wdata=0x12345678 while s_req[2]=1.
REQ-036 Access to 0xF000_0000 with NUM_SLV=4 -> no s_req asserted; m_ack and m_err asserted one cycle after req.
REQ-037 Slave never acks, TIMEOUT=8 -> s_req high for 8 cycles, then m_ack=1, m_err=1, m_rdata=0.
REQ-038 rst pulsed during BUSY -> s_req=0 the next cycle, no m_ack, and a new request afterwards completes normally.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: two-master, NUM_SLV-slave single-outstanding bus fabric.
// A round-robin arbiter grants one master, the address top nibble selects the
// slave, and a wait counter bounds how long a slave may stall before an error.
module soc_bus_fabric #(
    parameter int unsigned NUM_SLV    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      m_req,
    input  logic [2*(DATA_WIDTH/8)-1:0]     m_we,
    input  logic [2*ADDR_WIDTH-1:0]         m_addr,
    input  logic [2*DATA_WIDTH-1:0]         m_wdata,
    output logic [1:0]                      m_ack,
    output logic [1:0]                      m_err,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [NUM_SLV-1:0]              s_req,
    output logic [DATA_WIDTH/8-1:0]         s_we,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    input  logic [NUM_SLV-1:0]              s_ack,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]   s_rdata
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned IDX_CMP_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [STRB_W-1:0]     we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } txn_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;        // master granted most recently
    logic                  gnt_q, gnt_d;      // master owning the current transaction
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    txn_t                  txn_q, txn_d;
    logic [NUM_SLV-1:0]    s_req_q, s_req_d;
    logic [1:0]            m_ack_q, m_ack_d;
    logic [1:0]            m_err_q, m_err_d;
    logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;

    logic                  arb_gnt;
    txn_t                  cand_txn;
    logic [IDX_W-1:0]      cand_idx;
    logic                  cand_unmapped;
    logic [NUM_SLV-1:0]    cand_onehot;
    logic                  sel_ack;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [CNT_W-1:0]      cnt_inc;

    // Round-robin pick: on a tie the master not granted last wins.
    always_comb begin
        arb_gnt = (m_req == 2'b11) ? ~rr_q : m_req[1];
    end

    // Payload and slave decode of the candidate master.
    always_comb begin
        cand_txn.we    = arb_gnt ? m_we[STRB_W +: STRB_W]             : m_we[0 +: STRB_W];
        cand_txn.addr  = arb_gnt ? m_addr[ADDR_WIDTH +: ADDR_WIDTH]   : m_addr[0 +: ADDR_WIDTH];
        cand_txn.wdata = arb_gnt ? m_wdata[DATA_WIDTH +: DATA_WIDTH]  : m_wdata[0 +: DATA_WIDTH];
        cand_idx       = cand_txn.addr[ADDR_WIDTH-1 -: IDX_W];
        cand_unmapped  = ({1'b0, cand_idx} >= IDX_CMP_W'(NUM_SLV));
        cand_onehot    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            cand_onehot[i] = (cand_idx == IDX_W'(i));
        end
    end

    // Ack and read data of the selected slave only; other slaves are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output logic for IDLE/BUSY/RESP.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        txn_d     = txn_q;
        s_req_d   = s_req_q;
        m_ack_d   = '0;
        m_err_d   = '0;
        m_rdata_d = m_rdata_q;

        case (state_q)
            IDLE: begin
                if (|m_req) begin
                    gnt_d = arb_gnt;
                    txn_d = cand_txn;
                    sel_d = cand_idx;
                    cnt_d = '0;
                    if (cand_unmapped) begin
                        state_d          = RESP;
                        m_ack_d[arb_gnt] = 1'b1;
                        m_err_d[arb_gnt] = 1'b1;
                        m_rdata_d        = '0;
                    end else begin
                        state_d = BUSY;
                        s_req_d = cand_onehot;
                    end
                end
            end
            BUSY: begin
                if (sel_ack) begin
                    state_d        = RESP;
                    s_req_d        = '0;
                    m_ack_d[gnt_q] = 1'b1;
                    m_rdata_d      = (|txn_q.we) ? '0 : sel_rdata;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d        = RESP;
                    cnt_d          = cnt_inc;
                    s_req_d        = '0;
                    m_ack_d[gnt_q] = 1'b1;
                    m_err_d[gnt_q] = 1'b1;
                    m_rdata_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = gnt_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b1;
            gnt_q     <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            txn_q     <= '0;
            s_req_q   <= '0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            txn_q     <= txn_d;
            s_req_q   <= s_req_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign s_req   = s_req_q;
    assign s_we    = txn_q.we;
    assign s_addr  = txn_q.addr;
    assign s_wdata = txn_q.wdata;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Cycle-table bench for soc_bus_fabric plus hand-written timeout and reset sequences.
module tb_soc_bus_fabric;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    localparam logic [31:0] A0  = 32'h0000_0010;
    localparam logic [31:0] A1  = 32'h1000_0004;
    localparam logic [31:0] A2  = 32'h2000_0000;
    localparam logic [31:0] A3  = 32'h3000_0008;
    localparam logic [31:0] AU  = 32'hF000_0000;
    localparam logic [31:0] RD0 = 32'hA0A0_A0A0;
    localparam logic [31:0] RD1 = 32'hDEAD_BEEF;
    localparam logic [31:0] RD2 = 32'hC2C2_C2C2;
    localparam logic [31:0] RD3 = 32'hD3D3_D3D3;
    localparam logic [31:0] WD  = 32'h1234_5678;
    localparam logic [31:0] WX  = 32'hFFFF_0000;

    logic          clk;
    logic          rst;
    logic [1:0]    m_req;
    logic [7:0]    m_we;
    logic [63:0]   m_addr;
    logic [63:0]   m_wdata;
    logic [1:0]    m_ack;
    logic [1:0]    m_err;
    logic [31:0]   m_rdata;
    logic [3:0]    s_req;
    logic [3:0]    s_we;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_ack;
    logic [127:0]  s_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    soc_bus_fabric #(
        .NUM_SLV   (NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .m_rdata(m_rdata),
        .s_req  (s_req),
        .s_we   (s_we),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_ack  (s_ack),
        .s_rdata(s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic [1:0]  req;
        logic [3:0]  we0, we1;
        logic [31:0] a0, a1, wd0, wd1;
        logic [3:0]  sack;
        logic [1:0]  ack, err;
        logic [31:0] rdata;
        logic [3:0]  sreq, swe;
        logic [31:0] saddr, swdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string nm, input logic r, input logic [1:0] req,
                                input logic [3:0] we0, input logic [3:0] we1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic [3:0] sack, input logic [1:0] ack,
                                input logic [1:0] err, input logic [31:0] rdata,
                                input logic [3:0] sreq, input logic [3:0] swe,
                                input logic [31:0] saddr, input logic [31:0] swdata);
        vec_t v;
        v.nm = nm; v.rst = r; v.req = req; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1; v.sack = sack;
        v.ack = ack; v.err = err; v.rdata = rdata; v.sreq = sreq; v.swe = swe;
        v.saddr = saddr; v.swdata = swdata;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [107:0] act, exp;
        rst     = v.rst;
        m_req   = v.req;
        m_we    = {v.we1, v.we0};
        m_addr  = {v.a1, v.a0};
        m_wdata = {v.wd1, v.wd0};
        s_ack   = v.sack;
        cyc();
        act = {m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata};
        exp = {v.ack, v.err, v.rdata, v.sreq, v.swe, v.saddr, v.swdata};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got ack=%b err=%b rdata=%h sreq=%b swe=%b saddr=%h swdata=%h expected ack=%b err=%b rdata=%h sreq=%b swe=%b saddr=%h swdata=%h",
                     v.nm, m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata,
                     v.ack, v.err, v.rdata, v.sreq, v.swe, v.saddr, v.swdata);
        end
    endtask

    // Bounded run time: a hang is reported and stops the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = '0;
        s_rdata = {RD3, RD2, RD1, RD0};

        //           name                 rst req  we0   we1      a0  a1  wd0 wd1  sack     ack    err    rdata sreq     swe      saddr swdata
        vq.push_back(mk("reset",            1, 2'b00, 4'h0, 4'h0,    0,  0,  0,  0,  4'b0000, 2'b00, 2'b00, 0,    4'b0000, 4'h0,    0,  0));
        vq.push_back(mk("idle",             0, 2'b00, 4'h0, 4'h0,    0,  0,  0,  0,  4'b0000, 2'b00, 2'b00, 0,    4'b0000, 4'h0,    0,  0));
        vq.push_back(mk("both req m0 wins", 0, 2'b11, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, 0,    4'b0001, 4'h0,    A0, 0));
        vq.push_back(mk("s0 ack m0",        0, 2'b11, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0001, 2'b01, 2'b00, RD0,  4'b0000, 4'h0,    A0, 0));
        vq.push_back(mk("m0 drop",          0, 2'b10, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD0,  4'b0000, 4'h0,    A0, 0));
        vq.push_back(mk("m1 grant",         0, 2'b10, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD0,  4'b0100, 4'h0,    A2, 0));
        vq.push_back(mk("stray s1 ack",     0, 2'b10, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0010, 2'b00, 2'b00, RD0,  4'b0100, 4'h0,    A2, 0));
        vq.push_back(mk("s2 ack m1",        0, 2'b10, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0100, 2'b10, 2'b00, RD2,  4'b0000, 4'h0,    A2, 0));
        vq.push_back(mk("m1 drop",          0, 2'b00, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD2,  4'b0000, 4'h0,    A2, 0));
        vq.push_back(mk("m0 rd A1",         0, 2'b01, 4'h0, 4'h0,    A1, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD2,  4'b0010, 4'h0,    A1, 0));
        vq.push_back(mk("s1 ack deadbeef",  0, 2'b01, 4'h0, 4'h0,    A1, A2, 0,  0,  4'b0010, 2'b01, 2'b00, RD1,  4'b0000, 4'h0,    A1, 0));
        vq.push_back(mk("m0 drop 2",        0, 2'b00, 4'h0, 4'h0,    A1, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD1,  4'b0000, 4'h0,    A1, 0));
        vq.push_back(mk("both req m1 wins", 0, 2'b11, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD1,  4'b0100, 4'h0,    A2, 0));
        vq.push_back(mk("s2 ack m1 first",  0, 2'b11, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0100, 2'b10, 2'b00, RD2,  4'b0000, 4'h0,    A2, 0));
        vq.push_back(mk("m1 drop 2",        0, 2'b01, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD2,  4'b0000, 4'h0,    A2, 0));
        vq.push_back(mk("m0 grant second",  0, 2'b01, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD2,  4'b0001, 4'h0,    A0, 0));
        vq.push_back(mk("s0 ack m0 second", 0, 2'b01, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0001, 2'b01, 2'b00, RD0,  4'b0000, 4'h0,    A0, 0));
        vq.push_back(mk("m0 drop 3",        0, 2'b00, 4'h0, 4'h0,    A0, A2, 0,  0,  4'b0000, 2'b00, 2'b00, RD0,  4'b0000, 4'h0,    A0, 0));
        vq.push_back(mk("m1 write",         0, 2'b10, 4'h0, 4'b0011, A0, A2, 0,  WD, 4'b0000, 2'b00, 2'b00, RD0,  4'b0100, 4'b0011, A2, WD));
        vq.push_back(mk("m1 payload change",0, 2'b10, 4'h0, 4'b1111, A0, A3, 0,  WX, 4'b0000, 2'b00, 2'b00, RD0,  4'b0100, 4'b0011, A2, WD));
        vq.push_back(mk("s2 ack write",     0, 2'b10, 4'h0, 4'b1111, A0, A3, 0,  WX, 4'b0100, 2'b10, 2'b00, 0,    4'b0000, 4'b0011, A2, WD));
        vq.push_back(mk("m1 drop write",    0, 2'b00, 4'h0, 4'h0,    A0, A3, 0,  0,  4'b0000, 2'b00, 2'b00, 0,    4'b0000, 4'b0011, A2, WD));
        vq.push_back(mk("m0 unmapped",      0, 2'b01, 4'h0, 4'h0,    AU, A3, 0,  0,  4'b0000, 2'b01, 2'b01, 0,    4'b0000, 4'h0,    AU, 0));
        vq.push_back(mk("m0 drop unmapped", 0, 2'b00, 4'h0, 4'h0,    AU, A3, 0,  0,  4'b0000, 2'b00, 2'b00, 0,    4'b0000, 4'h0,    AU, 0));

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
        end

        // Slave 3 never acks while other slaves ack spuriously: expect TO cycles of s_req.
        m_req  = 2'b01;
        m_addr = {A3, A3};
        m_we   = '0;
        s_ack  = 4'b0000;
        cyc();
        check("timeout sreq asserted", 64'(s_req), 64'(4'b1000));
        s_ack = 4'b0111;
        n = 0;
        while (s_req[3] && (m_ack == 2'b00) && (n < 20)) begin
            n++;
            cyc();
        end
        check("timeout sreq cycles", 64'(n), 64'(TO));
        check("timeout ack", 64'(m_ack), 64'(2'b01));
        check("timeout err", 64'(m_err), 64'(2'b01));
        check("timeout rdata", 64'(m_rdata), 64'(0));
        check("timeout sreq dropped", 64'(s_req), 64'(0));
        m_req = 2'b00;
        s_ack = 4'b0000;
        cyc();
        check("timeout ack one cycle", 64'({m_ack, m_err}), 64'(0));

        // Reset while BUSY abandons the transaction.
        m_req  = 2'b01;
        m_addr = {A2, A1};
        cyc();
        check("pre-reset sreq", 64'(s_req), 64'(4'b0010));
        rst = 1'b1;
        cyc();
        check("reset sreq", 64'(s_req), 64'(0));
        check("reset ack", 64'({m_ack, m_err}), 64'(0));
        rst   = 1'b0;
        m_req = 2'b00;
        cyc();
        check("post-reset no ack", 64'({m_ack, s_req}), 64'(0));

        // After reset master 0 wins a tie and completes normally.
        m_req  = 2'b11;
        m_addr = {A2, A1};
        cyc();
        check("post-reset grant m0", 64'({s_req, s_addr}), 64'({4'b0010, A1}));
        s_ack = 4'b0010;
        cyc();
        check("post-reset ack", 64'({m_ack, m_err}), 64'({2'b01, 2'b00}));
        check("post-reset rdata", 64'(m_rdata), 64'(RD1));
        m_req = 2'b10;
        s_ack = 4'b0000;
        cyc();
        check("post-reset ack clears", 64'(m_ack), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
